// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime
//  Description : Per-channel complementary gate-drive generator. Converts a
//                raw PWM stream into high-side/low-side drives with
//                programmable rising and falling dead bands. The outputs
//                never overlap.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_deadtime #(
  parameter int CH_NUM   = 4,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  input  logic [CH_NUM-1:0]   pwm_i,
  output logic [CH_NUM-1:0]   pwm_h_o,
  output logic [CH_NUM-1:0]   pwm_l_o,
  output logic [CH_NUM-1:0]   dt_act_o
);

  typedef enum logic [2:0] {
    ST_SAFE    = 3'd0,
    ST_LOW     = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HIGH    = 3'd3,
    ST_DT_FALL = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] C_CNT_ZERO = '0;
  localparam logic [DT_WIDTH-1:0] C_CNT_ONE  = DT_WIDTH'(1);

  logic [CH_NUM-1:0] r_pwm_q;

  // Entry decisions into a dead band are identical for every channel, so the
  // load value and target state are computed once from the live dead-time
  // inputs. They only take effect on the cycle a channel enters a DT state.
  state_t              w_rise_state;
  logic [DT_WIDTH-1:0] w_rise_cnt;
  state_t              w_fall_state;
  logic [DT_WIDTH-1:0] w_fall_cnt;

  // Single sampling stage for the upstream PWM; all channel decisions use it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm_q <= '0;
    end else begin
      r_pwm_q <= pwm_i;
    end
  end

  // Dead-band entry targets: a zero dead time skips straight to the new drive.
  always_comb begin
    w_rise_state = ST_DT_RISE;
    w_rise_cnt   = dt_rise_i - C_CNT_ONE;
    w_fall_state = ST_DT_FALL;
    w_fall_cnt   = dt_fall_i - C_CNT_ONE;
    if (dt_rise_i == C_CNT_ZERO) begin
      w_rise_state = ST_HIGH;
      w_rise_cnt   = C_CNT_ZERO;
    end
    if (dt_fall_i == C_CNT_ZERO) begin
      w_fall_state = ST_LOW;
      w_fall_cnt   = C_CNT_ZERO;
    end
  end

  generate
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      state_t              r_state;
      logic [DT_WIDTH-1:0] r_cnt;
      logic                r_h;
      logic                r_l;
      logic                r_dt;
      state_t              w_next_state;
      logic [DT_WIDTH-1:0] w_next_cnt;

      // Next-state logic; disable wins over every other transition.
      always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (!en_i) begin
          w_next_state = ST_SAFE;
          w_next_cnt   = C_CNT_ZERO;
        end else begin
          case (r_state)
            ST_SAFE: begin
              if (r_pwm_q[g]) begin
                w_next_state = w_rise_state;
                w_next_cnt   = w_rise_cnt;
              end else begin
                w_next_state = w_fall_state;
                w_next_cnt   = w_fall_cnt;
              end
            end
            ST_LOW: begin
              if (r_pwm_q[g]) begin
                w_next_state = w_rise_state;
                w_next_cnt   = w_rise_cnt;
              end
            end
            ST_HIGH: begin
              if (!r_pwm_q[g]) begin
                w_next_state = w_fall_state;
                w_next_cnt   = w_fall_cnt;
              end
            end
            ST_DT_RISE: begin
              if (!r_pwm_q[g]) begin
                w_next_state = ST_LOW;
                w_next_cnt   = C_CNT_ZERO;
              end else if (r_cnt == C_CNT_ZERO) begin
                w_next_state = ST_HIGH;
              end else begin
                w_next_cnt = r_cnt - C_CNT_ONE;
              end
            end
            ST_DT_FALL: begin
              if (r_pwm_q[g]) begin
                w_next_state = ST_HIGH;
                w_next_cnt   = C_CNT_ZERO;
              end else if (r_cnt == C_CNT_ZERO) begin
                w_next_state = ST_LOW;
              end else begin
                w_next_cnt = r_cnt - C_CNT_ONE;
              end
            end
            default: begin
              w_next_state = ST_SAFE;
              w_next_cnt   = C_CNT_ZERO;
            end
          endcase
        end
      end

      // State, counter and gate drives registered together; outputs are
      // decoded from the next state so they change on the same edge.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_state <= ST_SAFE;
          r_cnt   <= C_CNT_ZERO;
          r_h     <= 1'b0;
          r_l     <= 1'b0;
          r_dt    <= 1'b0;
        end else begin
          r_state <= w_next_state;
          r_cnt   <= w_next_cnt;
          r_h     <= (w_next_state == ST_HIGH);
          r_l     <= (w_next_state == ST_LOW);
          r_dt    <= (w_next_state == ST_DT_RISE) || (w_next_state == ST_DT_FALL);
        end
      end

      assign pwm_h_o[g]  = r_h;
      assign pwm_l_o[g]  = r_l;
      assign dt_act_o[g] = r_dt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_deadtime
//  Description : Self-checking bench for pwm_deadtime. Each scenario queues
//                the expected per-cycle drive of one channel ('S' safe,
//                'L' low, 'D' dead band, 'H' high) and pops it as the DUT
//                produces each cycle's output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_deadtime;

  localparam int CH_NUM   = 4;
  localparam int DT_WIDTH = 8;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                en_i;
  logic [DT_WIDTH-1:0] dt_rise_i;
  logic [DT_WIDTH-1:0] dt_fall_i;
  logic [CH_NUM-1:0]   pwm_i;
  logic [CH_NUM-1:0]   pwm_h_o;
  logic [CH_NUM-1:0]   pwm_l_o;
  logic [CH_NUM-1:0]   dt_act_o;

  int  checks = 0;
  int  errors = 0;
  byte exp_q[$];

  pwm_deadtime #(.CH_NUM(CH_NUM), .DT_WIDTH(DT_WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .dt_rise_i(dt_rise_i),
    .dt_fall_i(dt_fall_i),
    .pwm_i    (pwm_i),
    .pwm_h_o  (pwm_h_o),
    .pwm_l_o  (pwm_l_o),
    .dt_act_o (dt_act_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected {h, l, dt} for a drive code.
  function automatic logic [2:0] dec(input byte c);
    case (c)
      "H":     return 3'b100;
      "L":     return 3'b010;
      "D":     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    string rst_s = "1100000";
    string exp_s = "SSDDDLL";
    byte c;
    logic [2:0] obs;
    en_i = 1'b1; pwm_i = '0; dt_rise_i = 8'd3; dt_fall_i = 8'd3;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < rst_s.len(); k++) begin
      rst_i = (rst_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[0], pwm_l_o[0], dt_act_o[0]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL reset_exit cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
      if (k == 0) begin
        checks++;
        if ({pwm_h_o, pwm_l_o, dt_act_o} !== '0) begin
          errors++;
          $display("FAIL reset_all: got h=%b l=%b dt=%b expected all 0", pwm_h_o, pwm_l_o, dt_act_o);
        end
      end
    end
  endtask

  task automatic test_deadtime();
    string pwm_s = "111111000000";
    string exp_s = "LDDDHHHDDDLL";
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd3; dt_fall_i = 8'd3;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < pwm_s.len(); k++) begin
      pwm_i[0] = (pwm_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[0], pwm_l_o[0], dt_act_o[0]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL deadtime3 cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
    end
  endtask

  task automatic test_zero_dt();
    string pwm_s = "1010101000";
    string exp_s = "LHLHLHLHLL";
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd0; dt_fall_i = 8'd0;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < pwm_s.len(); k++) begin
      pwm_i[1] = (pwm_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[1], pwm_l_o[1], dt_act_o[1]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL zero_dt cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
    end
  endtask

  task automatic test_abort();
    string pwm_s = "11000000";
    string exp_s = "LDDLLLLL";
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd5; dt_fall_i = 8'd5;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < pwm_s.len(); k++) begin
      pwm_i[2] = (pwm_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[2], pwm_l_o[2], dt_act_o[2]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL rise_abort cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
    end
  endtask

  task automatic test_enable();
    string en_s  = "111101111111";
    string pwm_s = "111111110000";
    string exp_s = "LDDHSDDHHDDL";
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd2; dt_fall_i = 8'd2;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < pwm_s.len(); k++) begin
      en_i     = (en_s[k] == "1");
      pwm_i[3] = (pwm_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[3], pwm_l_o[3], dt_act_o[3]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL enable_safe cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
    end
    en_i = 1'b1;
  endtask

  task automatic test_dt_change();
    string pwm_s = "1111110011100";
    string exp_s = "LDDDDHHLLDHHL";
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd4; dt_fall_i = 8'd0;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < pwm_s.len(); k++) begin
      if (k == 2) dt_rise_i = 8'd1;
      pwm_i[0] = (pwm_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[0], pwm_l_o[0], dt_act_o[0]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL dt_change cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
    end
  endtask

  task automatic test_max_dt();
    int n = 0;
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd255; dt_fall_i = 8'd0;
    exp_q.push_back("L");
    for (int k = 0; k < 255; k++) exp_q.push_back("D");
    exp_q.push_back("H");
    exp_q.push_back("H");
    exp_q.push_back("L");
    while (exp_q.size() > 0) begin
      pwm_i[1] = (n < 257);
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[1], pwm_l_o[1], dt_act_o[1]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL max_dt cycle %0d: got h/l/dt=%b expected %b", n, obs, dec(c));
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    string rst_s = "000000100";
    string pwm_s = "111000000";
    string exp_s = "LDHHDDSLL";
    byte c;
    logic [2:0] obs;
    dt_rise_i = 8'd1; dt_fall_i = 8'd255;
    for (int k = 0; k < exp_s.len(); k++) exp_q.push_back(exp_s[k]);
    for (int k = 0; k < pwm_s.len(); k++) begin
      if (k == 7) dt_fall_i = 8'd0;
      rst_i    = (rst_s[k] == "1");
      pwm_i[0] = (pwm_s[k] == "1");
      tick();
      c   = exp_q.pop_front();
      obs = {pwm_h_o[0], pwm_l_o[0], dt_act_o[0]};
      checks++;
      if (obs !== dec(c)) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got h/l/dt=%b expected %b", k, obs, dec(c));
      end
      if (k == 6) begin
        checks++;
        if ({pwm_h_o, pwm_l_o, dt_act_o} !== '0) begin
          errors++;
          $display("FAIL reset_mid_all: got h=%b l=%b dt=%b expected all 0", pwm_h_o, pwm_l_o, dt_act_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int overlap_err = 0;
    for (int k = 0; k < 20000; k++) begin
      en_i      = ($urandom_range(0, 15) != 0);
      rst_i     = ($urandom_range(0, 199) == 0);
      pwm_i     = CH_NUM'($urandom);
      dt_rise_i = DT_WIDTH'($urandom_range(0, 6));
      dt_fall_i = DT_WIDTH'($urandom_range(0, 6));
      tick();
      checks++;
      if ((pwm_h_o & pwm_l_o) !== '0) begin
        errors++;
        overlap_err++;
        if (overlap_err < 10)
          $display("FAIL overlap cycle %0d: got h=%b l=%b expected no common bit", k, pwm_h_o, pwm_l_o);
      end
      if (rst_i || !en_i) begin
        checks++;
        if ((pwm_h_o | pwm_l_o) !== '0) begin
          errors++;
          $display("FAIL forced_safe cycle %0d: got h=%b l=%b expected 0", k, pwm_h_o, pwm_l_o);
        end
      end
    end
    rst_i = 1'b0;
    en_i  = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; pwm_i = '0; dt_rise_i = '0; dt_fall_i = '0;
    test_reset();
    test_deadtime();
    test_zero_dt();
    test_abort();
    test_enable();
    test_dt_change();
    test_max_dt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
